// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: pipelined IEEE-754-style floating-point multiplier.
// Three registered stages (classify/multiply, normalise, round/pack) behind a
// valid/ready handshake. The whole pipe advances together, and bubbles are kept.
// Optional status accumulator: define FP_MULT_PIPE_STATUS_ACC_EN to add the
// clr_acc input and status_acc output.
// status = {zero, inf, nan, tiny, huge, inexact, 0, 0}

module fp_mult_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   input  logic [2:0]             rnd,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   z,
   output logic [7:0]             status
`ifdef FP_MULT_PIPE_STATUS_ACC_EN
   ,
   input  logic                   clr_acc,
   output logic [7:0]             status_acc
`endif
);

   localparam int SW = MAN_W + 1;
   localparam int PW = 2 * SW;
   localparam int EW = EXP_W + 2;
   localparam int BIAS_I = (1 << (EXP_W - 1)) - 1;
   localparam int EXP_MAX_I = (1 << EXP_W) - 1;
   localparam logic signed [EW-1:0] BIAS = EW'(BIAS_I);
   localparam logic signed [EW-1:0] EXP_MAX = EW'(EXP_MAX_I);

   typedef enum logic [2:0] {
      RND_RNE = 3'd0,
      RND_RTZ = 3'd1,
      RND_RUP = 3'd2,
      RND_RDN = 3'd3,
      RND_RMM = 3'd4,
      RND_RAZ = 3'd5
   } rnd_mode_t;

   logic advance;

   // operand fields and stage-1 combinational results
   logic                   a_sign, b_sign;
   logic [EXP_W-1:0]       a_exp, b_exp;
   logic [MAN_W-1:0]       a_man, b_man;
   logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [SW-1:0]          sig_a, sig_b;
   logic [PW-1:0]          prod_c;
   logic signed [EW-1:0]   exp_c;
   logic                   nan_c, inf_c, zero_c;
   rnd_mode_t              mode_c;

   // stage-1 registers
   logic                   s1_valid, s1_sign, s1_nan, s1_inf, s1_zero;
   logic signed [EW-1:0]   s1_exp;
   logic [PW-1:0]          s1_prod;
   rnd_mode_t              s1_mode;

   // stage-2 combinational results
   logic signed [EW-1:0]   exp_n;
   logic [MAN_W-1:0]       man_n;
   logic                   guard_n, sticky_n;

   // stage-2 registers
   logic                   s2_valid, s2_sign, s2_nan, s2_inf, s2_zero;
   logic signed [EW-1:0]   s2_exp;
   logic [MAN_W-1:0]       s2_man;
   logic                   s2_guard, s2_sticky;
   rnd_mode_t              s2_mode;

   // stage-3 combinational results
   logic                   inc, to_inf, to_min, ovf, uf, gs;
   logic [SW-1:0]          man_r;
   logic signed [EW-1:0]   exp_r;
   logic                   f_zero, f_inf, f_nan, f_tiny, f_huge, f_inx;
   logic [EXP_W+MAN_W:0]   z_n;

   assign advance  = !out_valid | out_ready;
   assign in_ready = advance;

   assign {a_sign, a_exp, a_man} = a;
   assign {b_sign, b_exp, b_man} = b;

   // Classify operands (subnormals flush to zero), form biased exponent and full product
   always_comb begin
      a_zero = (a_exp == '0);
      b_zero = (b_exp == '0);
      a_inf  = (a_exp == '1) && (a_man == '0);
      b_inf  = (b_exp == '1) && (b_man == '0);
      a_nan  = (a_exp == '1) && (a_man != '0);
      b_nan  = (b_exp == '1) && (b_man != '0);
      sig_a  = a_zero ? '0 : {1'b1, a_man};
      sig_b  = b_zero ? '0 : {1'b1, b_man};
      prod_c = {{SW{1'b0}}, sig_a} * {{SW{1'b0}}, sig_b};
      exp_c  = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS;
      nan_c  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
      inf_c  = !nan_c & (a_inf | b_inf);
      zero_c = !nan_c & !inf_c & (a_zero | b_zero);
      mode_c = (rnd > 3'd5) ? RND_RNE : rnd_mode_t'(rnd);
   end

   // Stage 1 register: capture classification, exponent and raw product
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_nan   <= 1'b0;
         s1_inf   <= 1'b0;
         s1_zero  <= 1'b0;
         s1_exp   <= '0;
         s1_prod  <= '0;
         s1_mode  <= RND_RNE;
      end else if (advance) begin
         s1_valid <= in_valid;
         s1_sign  <= a_sign ^ b_sign;
         s1_nan   <= nan_c;
         s1_inf   <= inf_c;
         s1_zero  <= zero_c;
         s1_exp   <= exp_c;
         s1_prod  <= prod_c;
         s1_mode  <= mode_c;
      end
   end

   // Normalise the product into [1,2) and split off guard and sticky bits
   always_comb begin
      if (s1_prod[PW-1]) begin
         exp_n    = s1_exp + EW'(1);
         man_n    = s1_prod[PW-2 -: MAN_W];
         guard_n  = s1_prod[PW-2-MAN_W];
         sticky_n = |s1_prod[PW-3-MAN_W:0];
      end else begin
         exp_n    = s1_exp;
         man_n    = s1_prod[PW-3 -: MAN_W];
         guard_n  = s1_prod[PW-3-MAN_W];
         sticky_n = |s1_prod[PW-4-MAN_W:0];
      end
   end

   // Stage 2 register: normalised mantissa with rounding information
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid  <= 1'b0;
         s2_sign   <= 1'b0;
         s2_nan    <= 1'b0;
         s2_inf    <= 1'b0;
         s2_zero   <= 1'b0;
         s2_exp    <= '0;
         s2_man    <= '0;
         s2_guard  <= 1'b0;
         s2_sticky <= 1'b0;
         s2_mode   <= RND_RNE;
      end else if (advance) begin
         s2_valid  <= s1_valid;
         s2_sign   <= s1_sign;
         s2_nan    <= s1_nan;
         s2_inf    <= s1_inf;
         s2_zero   <= s1_zero;
         s2_exp    <= exp_n;
         s2_man    <= man_n;
         s2_guard  <= guard_n;
         s2_sticky <= sticky_n;
         s2_mode   <= s1_mode;
      end
   end

   // Round, renormalise on carry, saturate on over/underflow, then apply exception overrides
   always_comb begin
      gs = s2_guard | s2_sticky;
      case (s2_mode)
         RND_RNE: inc = s2_guard & (s2_sticky | s2_man[0]);
         RND_RTZ: inc = 1'b0;
         RND_RUP: inc = !s2_sign & gs;
         RND_RDN: inc = s2_sign & gs;
         RND_RMM: inc = s2_guard;
         RND_RAZ: inc = gs;
         default: inc = 1'b0;
      endcase
      case (s2_mode)
         RND_RTZ: to_inf = 1'b0;
         RND_RUP: to_inf = !s2_sign;
         RND_RDN: to_inf = s2_sign;
         default: to_inf = 1'b1;
      endcase
      case (s2_mode)
         RND_RAZ: to_min = 1'b1;
         RND_RUP: to_min = !s2_sign;
         RND_RDN: to_min = s2_sign;
         default: to_min = 1'b0;
      endcase

      man_r = {1'b0, s2_man} + {{MAN_W{1'b0}}, inc};
      exp_r = s2_exp + $signed({{(EW-1){1'b0}}, man_r[MAN_W]});
      ovf   = !exp_r[EW-1] && (exp_r >= EXP_MAX);
      uf    = exp_r[EW-1] || (exp_r == '0);

      z_n    = {s2_sign, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
      f_zero = 1'b0;
      f_inf  = 1'b0;
      f_nan  = 1'b0;
      f_tiny = 1'b0;
      f_huge = 1'b0;
      f_inx  = gs;

      if (s2_nan) begin
         z_n   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         f_nan = 1'b1;
         f_inx = 1'b0;
      end else if (s2_inf) begin
         z_n   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         f_inf = 1'b1;
         f_inx = 1'b0;
      end else if (s2_zero) begin
         z_n    = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
         f_zero = 1'b1;
         f_inx  = 1'b0;
      end else if (ovf) begin
         f_huge = 1'b1;
         f_inx  = 1'b1;
         if (to_inf) begin
            z_n   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            f_inf = 1'b1;
         end else begin
            z_n = {s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
         end
      end else if (uf) begin
         f_tiny = 1'b1;
         f_inx  = 1'b1;
         if (to_min) begin
            z_n = {s2_sign, {(EXP_W-1){1'b0}}, 1'b1, {MAN_W{1'b0}}};
         end else begin
            z_n    = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
            f_zero = 1'b1;
         end
      end
   end

   // Output register: results only load when a valid op leaves stage 2, so z holds under backpressure
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         z         <= '0;
         status    <= '0;
      end else if (advance) begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            z      <= z_n;
            status <= {f_zero, f_inf, f_nan, f_tiny, f_huge, f_inx, 2'b00};
         end
      end
   end

`ifdef FP_MULT_PIPE_STATUS_ACC_EN
   // Sticky status accumulator over transferred results; clear beats a same-cycle update
   always_ff @(posedge clk) begin
      if (rst) begin
         status_acc <= '0;
      end else if (clr_acc) begin
         status_acc <= '0;
      end else if (out_valid && out_ready) begin
         status_acc <= status_acc | status;
      end
   end
`endif

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: directed scoreboard bench for fp_mult_pipe (binary32 shape).
// Stimulus pushes hand-computed {z, status} into a queue at acceptance; a
// negedge monitor pops and compares on every output transfer.

module tb_fp_mult_pipe;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  rnd;
      logic [31:0] z;
      logic [7:0]  st;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [2:0]  rnd = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] z;
   logic [7:0]  status;
`ifdef FP_MULT_PIPE_STATUS_ACC_EN
   logic        clr_acc = 1'b0;
   logic [7:0]  status_acc;
`endif

   int          check_cnt = 0;
   int          pass_cnt = 0;
   logic [39:0] exp_q[$];
   vec_t        vecs[$];
   logic        held = 1'b0;
   logic [39:0] held_val = '0;

   fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .rnd       (rnd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .status    (status)
`ifdef FP_MULT_PIPE_STATUS_ACC_EN
      ,
      .clr_acc    (clr_acc),
      .status_acc (status_acc)
`endif
   );

   // free-running clock
   always #5 clk = ~clk;

   // record one comparison
   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
      check_cnt++;
      if (act === req) pass_cnt++;
      else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
   endfunction

   // drive one operand pair until accepted, pushing its expected result on acceptance
   task automatic apply_stimulus(input vec_t v);
      int   waited = 0;
      logic accepted = 1'b0;
      a = v.a;
      b = v.b;
      rnd = v.rnd;
      in_valid = 1'b1;
      while (!accepted && waited < 100) begin
         @(negedge clk);
         if (in_ready && !rst) begin
            accepted = 1'b1;
            exp_q.push_back({v.z, v.st});
         end
         @(posedge clk);
         #1;
         waited++;
      end
      in_valid = 1'b0;
      check("accept", 64'(accepted), 64'(1));
   endtask

   // wait for the scoreboard to empty and the output to go idle
   task automatic check_output();
      int waited = 0;
      while ((exp_q.size() != 0 || out_valid) && waited < 100) begin
         @(posedge clk);
         #1;
         waited++;
      end
      check("drain", 64'(exp_q.size()), 64'(0));
   endtask

   // monitor: compare each transferring output and confirm stalled outputs hold
   always @(negedge clk) begin
      if (rst || !out_valid) begin
         held = 1'b0;
      end else begin
         if (held) check("stall_hold", 64'({z, status}), 64'(held_val));
         if (out_ready) begin
            held = 1'b0;
            if (exp_q.size() == 0) check("unexpected_output", 64'(exp_q.size()), 64'(1));
            else check("result", 64'({z, status}), 64'(exp_q.pop_front()));
         end else begin
            held = 1'b1;
            held_val = {z, status};
         end
      end
   end

   // watchdog
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int stale;
      //               a             b             rnd   z             status
      vecs.push_back({32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 8'h00});
      vecs.push_back({32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 8'h04});
      vecs.push_back({32'h3F800001, 32'h3F800001, 3'd2, 32'h3F800003, 8'h04});
      vecs.push_back({32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 8'h04});
      vecs.push_back({32'h3F800001, 32'h3F800001, 3'd5, 32'h3F800003, 8'h04});
      vecs.push_back({32'h7F000000, 32'h40000000, 3'd0, 32'h7F800000, 8'h4C});
      vecs.push_back({32'h7F000000, 32'h40000000, 3'd1, 32'h7F7FFFFF, 8'h0C});
      vecs.push_back({32'hFF000000, 32'h40000000, 3'd2, 32'hFF7FFFFF, 8'h0C});
      vecs.push_back({32'hFF000000, 32'h40000000, 3'd3, 32'hFF800000, 8'h4C});
      vecs.push_back({32'h00800000, 32'h3F000000, 3'd0, 32'h00000000, 8'h94});
      vecs.push_back({32'h00800000, 32'h3F000000, 3'd5, 32'h00800000, 8'h14});
      vecs.push_back({32'h80800000, 32'h3F000000, 3'd2, 32'h80000000, 8'h94});
      vecs.push_back({32'h80800000, 32'h3F000000, 3'd3, 32'h80800000, 8'h14});
      vecs.push_back({32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 8'h20});
      vecs.push_back({32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 8'h40});
      vecs.push_back({32'h80000000, 32'h40000000, 3'd0, 32'h80000000, 8'h80});
      vecs.push_back({32'h00000001, 32'h40000000, 3'd0, 32'h00000000, 8'h80});
      vecs.push_back({32'h7FC00001, 32'h3F800000, 3'd0, 32'h7FC00000, 8'h20});
      vecs.push_back({32'h3FC00000, 32'h3F800003, 3'd0, 32'h3FC00004, 8'h04});
      vecs.push_back({32'h3FC00000, 32'h3F800003, 3'd4, 32'h3FC00005, 8'h04});
      vecs.push_back({32'h3FC00000, 32'h3F800003, 3'd6, 32'h3FC00004, 8'h04});
      vecs.push_back({32'h3FFFFFFE, 32'h3F800001, 3'd0, 32'h40000000, 8'h04});
      vecs.push_back({32'h3FFFFFFE, 32'h3F800001, 3'd1, 32'h3FFFFFFF, 8'h04});
      vecs.push_back({32'h7F000000, 32'h3FC00000, 3'd0, 32'h7F400000, 8'h00});

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", 64'(out_valid), 64'(0));
      check("reset_z", 64'(z), 64'(0));
      check("reset_status", 64'(status), 64'(0));
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("in_ready_after_reset", 64'(in_ready), 64'(1));

      // first op: latency of exactly three cycles
      apply_stimulus(vecs[0]);
      check("latency_c1", 64'(out_valid), 64'(0));
      @(posedge clk);
      #1;
      check("latency_c2", 64'(out_valid), 64'(0));
      @(posedge clk);
      #1;
      check("latency_c3", 64'(out_valid), 64'(1));
      check_output();

      // directed vectors back to back
      for (int i = 1; i < vecs.size(); i++) apply_stimulus(vecs[i]);
      check_output();

      // backpressure: six ops while the sink stalls for five cycles
      fork
         begin
            for (int i = 0; i < 6; i++) apply_stimulus(vecs[i]);
         end
         begin
            out_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            check("in_ready_full", 64'(in_ready), 64'(0));
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      check_output();

      // reset mid-stream discards in-flight ops
      apply_stimulus(vecs[2]);
      apply_stimulus(vecs[6]);
      apply_stimulus(vecs[10]);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      check("midreset_out_valid", 64'(out_valid), 64'(0));
      rst = 1'b0;
      stale = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (out_valid) stale++;
      end
      check("midreset_stale", 64'(stale), 64'(0));

      // recovery after reset
      apply_stimulus(vecs[14]);
      check_output();

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
- Pipelined, parameterised IEEE-754-style floating-point multiplier. Successor to the single-cycle combinational multiplier.
- Generalised exponent/mantissa widths; registered 3-stage datapath with valid/ready handshake on both sides.
- Same rounding-mode encoding and 8-bit status layout as the combinational unit, so it drops into existing FP datapaths.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
- MAN_W, 23, stored mantissa width (hidden bit implied)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands this cycle
- a  in  1+EXP_W+MAN_W  operand A {sign, exp, man}
- b  in  1+EXP_W+MAN_W  operand B
- rnd  in  3  rounding mode; captured with operands
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- z  out  1+EXP_W+MAN_W  product
- status  out  8  {zero, inf, nan, tiny, huge, inexact, 0, 0}

Behaviour:
- Reset: out_valid=0, z=0, status=0, all stage valids=0. in_ready=1 from the first cycle after reset. Reset mid-operation discards all in-flight ops.
- Handshake:
  - advance = !out_valid | out_ready; in_ready = advance.
  - Transfer occurs on in_valid & in_ready. The whole pipe stalls when advance=0; bubbles are not collapsed.
  - Latency is exactly 3 cycles from accept to out_valid with no stall. Throughput is 1 per cycle.
  - z and status are held stable while out_valid & !out_ready. Results leave in acceptance order.
- S1:
  - Classify operands. Exp==0 is treated as zero; denormals are flushed to zero.
  - sign = a.s ^ b.s.
  - exp = ea + eb - bias, computed in EXP_W+2 signed bits.
  - Full (MAN_W+1)x(MAN_W+1) product with hidden bits.
- S2:
  - Normalise: if product MSB is set, shift right by 1 and exp+1.
  - Take MAN_W mantissa bits; guard = next bit; sticky = OR of the remainder.
- S3: round, post-round renormalise, overflow/underflow detection, exception override, register outputs.
- Rounding modes (rnd):
  - 0 nearest-even.
  - 1 toward zero.
  - 2 toward +inf.
  - 3 toward -inf.
  - 4 nearest ties-up in magnitude.
  - 5 away from zero (increment if guard|sticky).
  - 6,7 behave as 0.
  - inexact = guard|sticky.
  - Mantissa carry-out shifts right by 1 and increments exp.
- Overflow (final exp >= 2^EXP_W-1): huge=1, inexact=1.
  - Result is ±inf for modes 0, 4, 5; max-normal for mode 1.
  - Mode 2: +inf if positive, else -max-normal.
  - Mode 3: -inf if negative, else +max-normal.
  - inf flag is set iff the output is inf.
- Underflow (final exp <= 0): tiny=1, inexact=1.
  - Result is ±0 for modes 0, 1, 4.
  - Mode 5: ±min-normal.
  - Mode 2: +min-normal if positive, else -0.
  - Mode 3: -min-normal if negative, else +0.
  - zero flag is set iff the output is zero.
- Exceptions (override arithmetic; tiny/huge/inexact = 0):
  - Any NaN input, or inf×0: canonical qNaN {0, all-ones, 1 followed by zeros}; nan=1.
  - inf×nonzero: signed inf; inf=1.
  - zero×finite: signed zero; zero=1.
- status[1:0] is always 0.

Optional Feature:
- Macro FP_MULT_PIPE_STATUS_ACC_EN.
- Defined:
  - Adds port clr_acc (in, 1) and status_acc (out, 8).
  - status_acc ORs in status on every output transfer (out_valid & out_ready).
  - clr_acc zeroes it the same cycle; clr_acc wins over a simultaneous OR.
  - rst clears it.
- Undefined: neither port exists and there is no accumulation logic.

Test Plan:
- a=0x3FC00000, b=0x40000000, rnd=0 -> z=0x40400000, status=0x00, out_valid exactly 3 cycles after accept.
- a=b=0x3F800001:
  - rnd=0 -> 0x3F800002, status=0x04.
  - rnd=2 -> 0x3F800003, status=0x04.
  - rnd=1 -> 0x3F800002, status=0x04.
- a=0x7F000000, b=0x40000000:
  - rnd=0 -> 0x7F800000, status=0x4C.
  - rnd=1 -> 0x7F7FFFFF, status=0x0C.
- a=0x00800000, b=0x3F000000:
  - rnd=0 -> 0x00000000, status=0x94.
  - rnd=5 -> 0x00800000, status=0x14.
- a=0x7F800000, b=0x00000000 -> 0x7FC00000, status=0x20. a=0xFF800000, b=0x40000000 -> 0xFF800000, status=0x40.
- Backpressure: stream 6 ops back-to-back with out_ready low for 5 cycles, then asserted.
  - in_ready drops once the pipe is full.
  - No loss or duplication; order preserved; z stable while stalled.
  - rst mid-stream -> out_valid=0 next cycle and no stale results emerge.
